// File: rtl/updown_sweep_pkg.sv
// rtl/updown_sweep_pkg.sv - shared types and constants for the sweep sequencer
package updown_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// rtl/updown_sweep_ctrl_if.sv - command/status bundle between command source and sequencer
interface updown_sweep_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [CNT_W-1:0] sweeps;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             ctrl;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] sweep_idx;

    modport master (
        output start, lo, hi, sweeps, abort,
        input  q, ctrl, busy, done, err, sweep_idx
    );

    modport slave (
        input  start, lo, hi, sweeps, abort,
        output q, ctrl, busy, done, err, sweep_idx
    );
endinterface

// File: rtl/updown_step_counter.sv
// rtl/updown_step_counter.sv - loadable up/down counter stepped by the sequencer
module updown_step_counter
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             ctrl,
    output logic [WIDTH-1:0] q
);

    // Load wins over stepping; the sequencer never asks for both at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= (ctrl == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - triangular sweep sequencer driving the up/down counter
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    updown_sweep_ctrl_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [CNT_W-1:0] sweeps_r;
    logic [CNT_W-1:0] sweep_idx;
    logic [CNT_W-1:0] next_idx;
    logic [WIDTH-1:0] q;
    logic             ctrl_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             start_ok;
    logic             last_sweep;
    logic             load;
    logic             en;
    logic             step_dir;

    assign start_ok   = bus.start && (bus.lo < bus.hi) && (bus.sweeps != '0);
    assign next_idx   = sweep_idx + CNT_W'(1);
    assign last_sweep = (next_idx == sweeps_r);

    // Counter control is decoded from the current state so the step lands on the same edge as the state change.
    always_comb begin
        load     = 1'b0;
        en       = 1'b0;
        step_dir = DIR_UP;
        case (state)
            IDLE: begin
                load = start_ok;
            end
            UP: begin
                if (!bus.abort) begin
                    en       = 1'b1;
                    step_dir = (q == hi_r) ? DIR_DOWN : DIR_UP;
                end
            end
            DOWN: begin
                if (!bus.abort) begin
                    if (q != lo_r) begin
                        en       = 1'b1;
                        step_dir = DIR_DOWN;
                    end else if (!last_sweep) begin
                        en       = 1'b1;
                        step_dir = DIR_UP;
                    end
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    updown_step_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (bus.lo),
        .en   (en),
        .ctrl (step_dir),
        .q    (q)
    );

    // Sequencer: run control, latched bounds, sweep count and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lo_r      <= '0;
            hi_r      <= '0;
            sweeps_r  <= '0;
            sweep_idx <= '0;
            ctrl_r    <= DIR_DOWN;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            lo_r      <= bus.lo;
                            hi_r      <= bus.hi;
                            sweeps_r  <= bus.sweeps;
                            sweep_idx <= '0;
                            ctrl_r    <= DIR_UP;
                            busy_r    <= 1'b1;
                            state     <= UP;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                UP: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (q == hi_r) begin
                        ctrl_r <= DIR_DOWN;
                        state  <= DOWN;
                    end
                end
                DOWN: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (q == lo_r) begin
                        sweep_idx <= next_idx;
                        if (last_sweep) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            ctrl_r <= DIR_UP;
                            state  <= UP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.q         = q;
    assign bus.ctrl      = ctrl_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.sweep_idx = sweep_idx;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - self-checking bench for updown_sweep_ctrl
module tb_updown_sweep_ctrl;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   model_q;
    int   model_idx;

    updown_sweep_ctrl_if #(.WIDTH(4), .CNT_W(4)) bus ();

    updown_sweep_ctrl #(
        .WIDTH (4),
        .CNT_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input int eq, input int ebusy,
                                input int edone, input int eerr, input int eidx);
        check({tag, ".q"},         32'(bus.q),         32'(eq));
        check({tag, ".busy"},      32'(bus.busy),      32'(ebusy));
        check({tag, ".done"},      32'(bus.done),      32'(edone));
        check({tag, ".err"},       32'(bus.err),       32'(eerr));
        check({tag, ".sweep_idx"}, 32'(bus.sweep_idx), 32'(eidx));
    endtask

    // act: 0 none, 1 abort at position act_k, 2 reset at position act_k.
    // Ends on the done cycle for a full run so a caller can start back-to-back.
    task automatic run(input int lo_v, input int hi_v, input int sw_v,
                       input int act_k, input int act, input bit pulse);
        int seq[$];
        int span;
        int eidx;
        int ectrl;
        span = hi_v - lo_v;
        seq.push_back(lo_v);
        for (int s = 0; s < sw_v; s++) begin
            for (int v = lo_v + 1; v <= hi_v; v++) seq.push_back(v);
            for (int v = hi_v - 1; v >= lo_v; v--) seq.push_back(v);
        end
        bus.lo     = 4'(lo_v);
        bus.hi     = 4'(hi_v);
        bus.sweeps = 4'(sw_v);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.lo     = 4'($urandom);
        bus.hi     = 4'($urandom);
        bus.sweeps = 4'($urandom);
        for (int k = 0; k < seq.size(); k++) begin
            eidx  = (k == 0) ? 0 : (k - 1) / (2 * span);
            ectrl = (k == 0) ? 1 : ((seq[k] > seq[k-1]) ? 1 : 0);
            check_status($sformatf("run k=%0d", k), seq[k], 1, 0, 0, eidx);
            check($sformatf("run k=%0d.ctrl", k), 32'(bus.ctrl), 32'(ectrl));
            if (act != 0 && k == act_k) begin
                if (act == 1) begin
                    bus.abort = 1'b1;
                    tick();
                    bus.abort = 1'b0;
                    check_status("abort", seq[k], 0, 0, 0, eidx);
                    model_q   = seq[k];
                    model_idx = eidx;
                end else begin
                    rst       = 1'b1;
                    bus.abort = 1'b1;
                    bus.start = 1'b1;
                    bus.lo    = 4'd1;
                    bus.hi    = 4'd9;
                    bus.sweeps = 4'd1;
                    tick();
                    rst       = 1'b0;
                    bus.abort = 1'b0;
                    bus.start = 1'b0;
                    check_status("reset_mid", 0, 0, 0, 0, 0);
                    check("reset_mid.ctrl", 32'(bus.ctrl), 32'd0);
                    model_q   = 0;
                    model_idx = 0;
                end
                return;
            end
            if (k < seq.size() - 1) begin
                if (pulse && (k == 2 || $urandom_range(0, 3) == 0)) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
        end
        tick();
        check_status("done", lo_v, 0, 1, 0, sw_v);
        model_q   = lo_v;
        model_idx = sw_v;
    endtask

    task automatic reject(input int lo_v, input int hi_v, input int sw_v);
        bus.lo     = 4'(lo_v);
        bus.hi     = 4'(hi_v);
        bus.sweeps = 4'(sw_v);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check_status("reject", model_q, 0, 0, 1, model_idx);
        tick();
        check_status("reject_after", model_q, 0, 0, 0, model_idx);
    endtask

    initial begin
        int lo_v;
        int hi_v;
        n_assert   = 0;
        n_fail     = 0;
        model_q    = 0;
        model_idx  = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.lo     = '0;
        bus.hi     = '0;
        bus.sweeps = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_status("idle", 0, 0, 0, 0, 0);
            check("idle.ctrl", 32'(bus.ctrl), 32'd0);
        end

        run(2, 5, 2, 0, 0, 1'b0);
        tick();
        check_status("done_drop", 2, 0, 0, 0, 2);

        reject(5, 5, 1);
        reject(1, 9, 0);
        reject(9, 3, 2);

        run(12, 15, 1, 0, 0, 1'b0);
        tick();
        check_status("done_drop_top", 12, 0, 0, 0, 1);

        run(0, 15, 1, 0, 0, 1'b0);
        tick();

        run(0, 8, 3, 4, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_status("post_abort", model_q, 0, 0, 0, model_idx);
        end

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_status("idle_abort", model_q, 0, 0, 0, model_idx);

        run(3, 7, 1, 6, 2, 1'b0);

        run(3, 6, 1, 0, 0, 1'b0);
        run(1, 4, 2, 0, 0, 1'b1);
        tick();
        check_status("b2b_drop", 1, 0, 0, 0, 2);

        for (int r = 0; r < 6; r++) begin
            lo_v = int'($urandom_range(0, 14));
            hi_v = int'($urandom_range(lo_v + 1, 15));
            run(lo_v, hi_v, int'($urandom_range(1, 3)), 0, 0, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                reject(hi_v, lo_v, 1);
            end
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
